// File: rtl/plot_pkg.sv
// Shared types and constants for the plot arbiter: requester ids, coordinate widths,
// default screen size and FSM state encoding.
package plot_pkg;

  localparam int NUM_REQ = 3;
  localparam int X_W     = 8;
  localparam int Y_W     = 7;
  localparam int C_W     = 3;

  localparam int SCREEN_W_DEFAULT = 160;
  localparam int SCREEN_H_DEFAULT = 120;

  typedef logic [1:0] owner_t;

  localparam owner_t REQ_CLEAR  = 2'd0;
  localparam owner_t REQ_TILES  = 2'd1;
  localparam owner_t REQ_DIGITS = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_HANDOFF = 2'd2
  } state_e;

  function automatic owner_t onehot_to_idx(input logic [NUM_REQ-1:0] oh);
    owner_t idx;
    idx = REQ_CLEAR;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (oh[i]) idx = owner_t'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/plot_arbiter_if.sv
// Bus between the pixel requesters and the arbiter, plus the VGA adapter write port.
// The master side drives requests and pixels; the arbiter is the slave.
interface plot_arbiter_if;
  import plot_pkg::*;

  logic [NUM_REQ-1:0]     req;
  logic [NUM_REQ-1:0]     plot_in;
  logic [NUM_REQ*X_W-1:0] x_in;
  logic [NUM_REQ*Y_W-1:0] y_in;
  logic [NUM_REQ*C_W-1:0] colour_in;

  logic [NUM_REQ-1:0]     grant;
  logic [X_W-1:0]         vga_x;
  logic [Y_W-1:0]         vga_y;
  logic [C_W-1:0]         vga_colour;
  logic                   vga_plot;
  logic                   busy;
  logic [7:0]             clip_count;

  modport master (
    output req, plot_in, x_in, y_in, colour_in,
    input  grant, vga_x, vga_y, vga_colour, vga_plot, busy, clip_count
  );

  modport slave (
    input  req, plot_in, x_in, y_in, colour_in,
    output grant, vga_x, vga_y, vga_colour, vga_plot, busy, clip_count
  );
endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin selection: the first requester at or after
// (last_owner+1) mod NUM_REQ wins; all-zero output when nobody requests.
module rr_picker
  import plot_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_i,
  input  owner_t             last_owner_i,
  output logic [NUM_REQ-1:0] winner_o
);

  // Walk from the farthest candidate to the nearest so the nearest one overrides.
  // NOTE: always_comb outputs get a default first so no path leaves them unassigned (no latch).
  always_comb begin
    winner_o = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      int idx;
      idx = (int'(last_owner_i) + k) % NUM_REQ;
      if (req_i[idx]) begin
        winner_o      = '0;
        winner_o[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/plot_arbiter.sv
// Three-way round-robin owner of the single VGA write port, no preemption.
// Optional off-screen clipping is enabled by defining PLOT_ARBITER_CLIP_EN.
module plot_arbiter
  import plot_pkg::*;
#(
  parameter int SCREEN_W = SCREEN_W_DEFAULT,
  parameter int SCREEN_H = SCREEN_H_DEFAULT
) (
  input  logic           clk,
  input  logic           resetn,
  plot_arbiter_if.slave  bus
);

  state_e             state_q;
  owner_t             owner_q;
  owner_t             last_owner_q;
  logic [NUM_REQ-1:0] grant_q;
  logic [NUM_REQ-1:0] winner;

  logic [X_W-1:0] x_sel,  vga_x_q,      vga_x_d;
  logic [Y_W-1:0] y_sel,  vga_y_q,      vga_y_d;
  logic [C_W-1:0] c_sel,  vga_colour_q, vga_colour_d;
  logic           vga_plot_q, vga_plot_d;
  logic           accept, off_screen, clip_hit;

  rr_picker u_rr_picker (
    .req_i        (bus.req),
    .last_owner_i (last_owner_q),
    .winner_o     (winner)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      owner_q      <= REQ_CLEAR;
      last_owner_q <= REQ_DIGITS;
    end else begin
      case (state_q)
        ST_IDLE: if (|bus.req) begin
          grant_q <= winner;
          owner_q <= onehot_to_idx(winner);
          state_q <= ST_BUSY;
        end
        ST_BUSY: if (!bus.req[owner_q]) begin
          grant_q      <= '0;
          last_owner_q <= owner_q;
          state_q      <= ST_HANDOFF;
        end
        ST_HANDOFF: state_q <= ST_IDLE;
        default:    state_q <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    x_sel = bus.x_in[X_W-1:0];
    y_sel = bus.y_in[Y_W-1:0];
    c_sel = bus.colour_in[C_W-1:0];
    case (owner_q)
      REQ_TILES: begin
        x_sel = bus.x_in[2*X_W-1:X_W];
        y_sel = bus.y_in[2*Y_W-1:Y_W];
        c_sel = bus.colour_in[2*C_W-1:C_W];
      end
      REQ_DIGITS: begin
        x_sel = bus.x_in[3*X_W-1:2*X_W];
        y_sel = bus.y_in[3*Y_W-1:2*Y_W];
        c_sel = bus.colour_in[3*C_W-1:2*C_W];
      end
      default: ;
    endcase
  end

  // A strobe in the cycle the owner drops req is ignored because req[owner] is required.
  assign accept = (state_q == ST_BUSY) && grant_q[owner_q]
                  && bus.req[owner_q] && bus.plot_in[owner_q];
  assign off_screen = (32'(x_sel) >= SCREEN_W) || (32'(y_sel) >= SCREEN_H);

`ifdef PLOT_ARBITER_CLIP_EN
  logic [7:0] clip_count_q;

  assign clip_hit = off_screen;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      clip_count_q <= '0;
    end else if (accept && clip_hit && (clip_count_q != 8'hFF)) begin
      clip_count_q <= clip_count_q + 8'd1;
    end
  end

  assign bus.clip_count = clip_count_q;
`else
  logic unused_off_screen;

  assign unused_off_screen = off_screen;
  assign clip_hit          = 1'b0;
  assign bus.clip_count    = '0;
`endif

  always_comb begin
    vga_plot_d   = accept && !clip_hit;
    vga_x_d      = vga_x_q;
    vga_y_d      = vga_y_q;
    vga_colour_d = vga_colour_q;
    if (vga_plot_d) begin
      vga_x_d      = x_sel;
      vga_y_d      = y_sel;
      vga_colour_d = c_sel;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vga_plot_q   <= 1'b0;
      vga_x_q      <= '0;
      vga_y_q      <= '0;
      vga_colour_q <= '0;
    end else begin
      vga_plot_q   <= vga_plot_d;
      vga_x_q      <= vga_x_d;
      vga_y_q      <= vga_y_d;
      vga_colour_q <= vga_colour_d;
    end
  end

  assign bus.grant      = grant_q;
  assign bus.busy       = |grant_q;
  assign bus.vga_plot   = vga_plot_q;
  assign bus.vga_x      = vga_x_q;
  assign bus.vga_y      = vga_y_q;
  assign bus.vga_colour = vga_colour_q;

endmodule

// File: tb/tb_plot_arbiter.sv
// Directed bench for plot_arbiter: arbitration order, handoff gaps, pixel forwarding,
// clipping (PLOT_ARBITER_CLIP_EN aware) and asynchronous reset mid-burst.
module tb_plot_arbiter;
  import plot_pkg::*;

  logic clk = 1'b0;
  logic resetn;
  int   n_cmp = 0;
  int   n_err = 0;

`ifdef PLOT_ARBITER_CLIP_EN
  localparam bit CLIP = 1'b1;
`else
  localparam bit CLIP = 1'b0;
`endif

  plot_arbiter_if bus ();

  plot_arbiter dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetn        = 1'b0;
    bus.req       = '0;
    bus.plot_in   = '0;
    bus.x_in      = '0;
    bus.y_in      = '0;
    bus.colour_in = '0;
    #3;
    check("rst_grant",  32'(bus.grant),      32'd0);
    check("rst_busy",   32'(bus.busy),       32'd0);
    check("rst_plot",   32'(bus.vga_plot),   32'd0);
    check("rst_x",      32'(bus.vga_x),      32'd0);
    check("rst_y",      32'(bus.vga_y),      32'd0);
    check("rst_colour", 32'(bus.vga_colour), 32'd0);
    check("rst_clip",   32'(bus.clip_count), 32'd0);
    tick();
    tick();

    // All three request together: clear, tiles, digits in turn.
    resetn  = 1'b1;
    bus.req = 3'b111;
    tick();
    check("first_grant", 32'(bus.grant), 32'b001);
    check("first_busy",  32'(bus.busy),  32'd1);
    bus.req = 3'b110;
    tick(); check("gap0_a", 32'(bus.grant), 32'b000);
    check("gap0_busy", 32'(bus.busy), 32'd0);
    tick(); check("gap0_b", 32'(bus.grant), 32'b000);
    tick(); check("grant_tiles", 32'(bus.grant), 32'b010);
    bus.req = 3'b100;
    tick(); check("gap1_a", 32'(bus.grant), 32'b000);
    tick(); check("gap1_b", 32'(bus.grant), 32'b000);
    tick(); check("grant_digits", 32'(bus.grant), 32'b100);
    bus.req = 3'b000;
    tick(); check("gap2_a", 32'(bus.grant), 32'b000);
    tick(); tick();
    check("idle_none", 32'(bus.grant), 32'b000);

    // Tiles and digits both want the port; from last_owner=2 tiles wins, no preemption.
    bus.req = 3'b110;
    tick(); check("tiles_win", 32'(bus.grant), 32'b010);
    bus.plot_in   = 3'b110;
    bus.x_in      = {8'd77, 8'd40, 8'd0};
    bus.y_in      = {7'd5, 7'd100, 7'd0};
    bus.colour_in = {3'd2, 3'd7, 3'd0};
    tick();
    check("pix_plot",   32'(bus.vga_plot),   32'd1);
    check("pix_x",      32'(bus.vga_x),      32'd40);
    check("pix_y",      32'(bus.vga_y),      32'd100);
    check("pix_colour", 32'(bus.vga_colour), 32'd7);
    check("no_preempt", 32'(bus.grant),      32'b010);
    bus.plot_in = 3'b100;
    tick();
    check("digits_ignored", 32'(bus.vga_plot), 32'd0);
    check("hold_x",         32'(bus.vga_x),    32'd40);
    check("hold_y",         32'(bus.vga_y),    32'd100);

    // Five back-to-back plots from the owner.
    bus.plot_in = 3'b010;
    for (int i = 0; i < 5; i++) begin
      bus.x_in      = {8'd77, 8'(10 + i), 8'd0};
      bus.y_in      = {7'd5, 7'(20 + i), 7'd0};
      bus.colour_in = {3'd2, 3'(i), 3'd0};
      tick();
      check($sformatf("burst%0d_plot", i), 32'(bus.vga_plot),   32'd1);
      check($sformatf("burst%0d_x", i),    32'(bus.vga_x),      32'(10 + i));
      check($sformatf("burst%0d_y", i),    32'(bus.vga_y),      32'(20 + i));
      check($sformatf("burst%0d_c", i),    32'(bus.vga_colour), 32'(i));
    end
    bus.plot_in = 3'b000;
    tick();
    check("burst_end_plot", 32'(bus.vga_plot), 32'd0);
    check("burst_end_x",    32'(bus.vga_x),    32'd14);

    // Screen edges: (160,0) and (0,120) are off-screen, (159,119) is the last pixel.
    bus.plot_in   = 3'b010;
    bus.x_in      = {8'd77, 8'd160, 8'd0};
    bus.y_in      = {7'd5, 7'd0, 7'd0};
    bus.colour_in = {3'd2, 3'd1, 3'd0};
    tick();
    check("edge_x_plot", 32'(bus.vga_plot), CLIP ? 32'd0 : 32'd1);
    check("edge_x_x",    32'(bus.vga_x),    CLIP ? 32'd14 : 32'd160);
    bus.x_in = {8'd77, 8'd0, 8'd0};
    bus.y_in = {7'd5, 7'd120, 7'd0};
    tick();
    check("edge_y_plot", 32'(bus.vga_plot), CLIP ? 32'd0 : 32'd1);
    check("edge_y_y",    32'(bus.vga_y),    CLIP ? 32'd24 : 32'd120);
    bus.x_in = {8'd77, 8'd159, 8'd0};
    bus.y_in = {7'd5, 7'd119, 7'd0};
    tick();
    check("corner_plot", 32'(bus.vga_plot), 32'd1);
    check("corner_x",    32'(bus.vga_x),    32'd159);
    check("corner_y",    32'(bus.vga_y),    32'd119);
    bus.plot_in = 3'b000;
    tick();
    check("clip_count", 32'(bus.clip_count), CLIP ? 32'd2 : 32'd0);

    // Owner drops req with a plot strobe in the same cycle: strobe ignored, grant clears.
    bus.req     = 3'b100;
    bus.plot_in = 3'b010;
    bus.x_in    = {8'd77, 8'd99, 8'd0};
    tick();
    check("drop_plot",  32'(bus.vga_plot), 32'd0);
    check("drop_grant", 32'(bus.grant),    32'b000);
    check("drop_x",     32'(bus.vga_x),    32'd159);
    bus.plot_in = 3'b000;
    tick();
    tick();
    check("digits_after_tiles", 32'(bus.grant), 32'b100);

    // Asynchronous reset in the middle of a digits burst.
    bus.plot_in = 3'b100;
    bus.x_in    = {8'd33, 8'd99, 8'd0};
    tick();
    check("pre_rst_plot", 32'(bus.vga_plot), 32'd1);
    check("pre_rst_x",    32'(bus.vga_x),    32'd33);
    resetn = 1'b0;
    #1;
    check("mid_rst_grant", 32'(bus.grant),      32'd0);
    check("mid_rst_plot",  32'(bus.vga_plot),   32'd0);
    check("mid_rst_busy",  32'(bus.busy),       32'd0);
    check("mid_rst_x",     32'(bus.vga_x),      32'd0);
    check("mid_rst_clip",  32'(bus.clip_count), 32'd0);
    tick();
    bus.plot_in = 3'b000;
    bus.req     = 3'b110;
    resetn      = 1'b1;
    tick();
    check("post_rst_grant", 32'(bus.grant), 32'b010);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
